// File: rtl/alu_seq.sv
// Sequential unsigned ALU: streams operands into an echo/add/multiply/divide
// accumulator and returns a single result with an error flag.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       opcode_i,
  input  logic             start_i,
  input  logic             operand_valid_i,
  input  logic [WIDTH-1:0] operand_i,
  input  logic             last_i,
  output logic             operand_ready_o,
  output logic             result_valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             err_o,
  input  logic             result_ready_i,
  output logic             busy_o,
  output logic [2:0]       dbg_state
);

  // Handshakes: a beat moves on a rising edge only when valid and ready are
  // both high; valid never depends on ready, and payload is held while valid.
  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'hAC;
  localparam logic [7:0] OP_DIV  = 8'hD1;
  localparam int         CNT_W   = $clog2(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state, state_next;
  logic [7:0]       opcode;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] shift_a;
  logic [WIDTH-1:0] shift_b;
  logic [WIDTH-1:0] result_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt;
  logic             have_dividend;
  logic             mul_last;

  logic             legal_op;
  logic             iter_done;
  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] mul_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] quo_next;

  assign legal_op  = (opcode_i == OP_ECHO) || (opcode_i == OP_ADD) ||
                     (opcode_i == OP_MUL)  || (opcode_i == OP_DIV);
  assign iter_done = (cnt == CNT_W'(WIDTH - 1));
  assign add_sum   = acc + operand_i;
  assign mul_sum   = shift_b[0] ? acc + shift_a : acc;

  // Restoring divide: acc holds the quotient and shifts the dividend out MSB first.
  assign rem_shift = {shift_a, acc[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, shift_b};
  assign q_bit     = ~trial[WIDTH];
  assign quo_next  = {acc[WIDTH-2:0], q_bit};

  assign result_o  = result_q;
  assign err_o     = err_q;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next      = state;
    operand_ready_o = 1'b0;
    result_valid_o  = 1'b0;
    busy_o          = 1'b1;
    case (state)
      S_IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_next = legal_op ? S_RECV : S_DONE;
      end
      S_RECV: begin
        operand_ready_o = 1'b1;
        if (operand_valid_i) begin
          case (opcode)
            OP_MUL: state_next = S_MUL;
            OP_DIV: begin
              if (have_dividend) state_next = (operand_i == '0) ? S_DONE : S_DIV;
              else if (last_i)   state_next = S_DONE;
            end
            default: if (last_i) state_next = S_DONE;
          endcase
        end
      end
      S_MUL:   if (iter_done) state_next = mul_last ? S_DONE : S_RECV;
      S_DIV:   if (iter_done) state_next = S_DONE;
      S_DONE: begin
        result_valid_o = 1'b1;
        if (result_ready_i) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode        <= '0;
      acc           <= '0;
      shift_a       <= '0;
      shift_b       <= '0;
      result_q      <= '0;
      err_q         <= 1'b0;
      cnt           <= '0;
      have_dividend <= 1'b0;
      mul_last      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            opcode        <= opcode_i;
            acc           <= (opcode_i == OP_MUL) ? WIDTH'(1) : '0;
            have_dividend <= 1'b0;
            mul_last      <= 1'b0;
            cnt           <= '0;
            if (!legal_op) begin
              result_q <= '0;
              err_q    <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (operand_valid_i) begin
            case (opcode)
              OP_ECHO: begin
                acc <= operand_i;
                if (last_i) begin
                  result_q <= operand_i;
                  err_q    <= 1'b0;
                end
              end
              OP_ADD: begin
                acc <= add_sum;
                if (last_i) begin
                  result_q <= add_sum;
                  err_q    <= 1'b0;
                end
              end
              OP_MUL: begin
                shift_a  <= acc;
                shift_b  <= operand_i;
                acc      <= '0;
                mul_last <= last_i;
                cnt      <= '0;
              end
              OP_DIV: begin
                if (!have_dividend) begin
                  acc           <= operand_i;
                  have_dividend <= 1'b1;
                  if (last_i) begin
                    result_q <= operand_i;
                    err_q    <= 1'b1;
                  end
                end else begin
                  shift_a <= '0;
                  shift_b <= operand_i;
                  cnt     <= '0;
                  if (operand_i == '0) begin
                    result_q <= '1;
                    err_q    <= 1'b1;
                  end
                end
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          acc     <= mul_sum;
          shift_a <= shift_a << 1;
          shift_b <= shift_b >> 1;
          cnt     <= cnt + CNT_W'(1);
          if (iter_done && mul_last) begin
            result_q <= mul_sum;
            err_q    <= 1'b0;
          end
        end
        S_DIV: begin
          shift_a <= q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
          acc     <= quo_next;
          cnt     <= cnt + CNT_W'(1);
          if (iter_done) begin
            result_q <= quo_next;
            err_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized checks of alu_seq against an arithmetic reference
// model of each command's result, error flag and latency.
module tb_alu_seq;

  localparam int W = 32;
  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'hAC;
  localparam logic [7:0] OP_DIV  = 8'hD1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   opcode_i = 8'h00;
  logic         start_i = 1'b0;
  logic         operand_valid_i = 1'b0;
  logic [W-1:0] operand_i = '0;
  logic         last_i = 1'b0;
  logic         operand_ready_o;
  logic         result_valid_o;
  logic [W-1:0] result_o;
  logic         err_o;
  logic         result_ready_i = 1'b0;
  logic         busy_o;
  logic [2:0]   dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] ops_q[$];

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .opcode_i(opcode_i), .start_i(start_i),
    .operand_valid_i(operand_valid_i), .operand_i(operand_i), .last_i(last_i),
    .operand_ready_o(operand_ready_o), .result_valid_o(result_valid_o),
    .result_o(result_o), .err_o(err_o), .result_ready_i(result_ready_i),
    .busy_o(busy_o), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: result and error from the operand list using plain arithmetic.
  function automatic logic [W:0] model(input logic [7:0] op);
    logic [63:0] acc;
    logic [63:0] mask;
    mask = (64'd1 << W) - 64'd1;
    case (op)
      OP_ECHO: return {1'b0, ops_q[ops_q.size()-1]};
      OP_ADD: begin
        acc = 0;
        foreach (ops_q[i]) acc = (acc + 64'(ops_q[i])) & mask;
        return {1'b0, acc[W-1:0]};
      end
      OP_MUL: begin
        acc = 1;
        foreach (ops_q[i]) acc = (acc * 64'(ops_q[i])) & mask;
        return {1'b0, acc[W-1:0]};
      end
      OP_DIV: begin
        if (ops_q.size() == 1) return {1'b1, ops_q[0]};
        if (ops_q[1] == 0)     return {1'b1, {W{1'b1}}};
        return {1'b0, ops_q[0] / ops_q[1]};
      end
      default: return {1'b1, {W{1'b0}}};
    endcase
  endfunction

  task automatic start_cmd(input logic [7:0] op);
    opcode_i = op;
    start_i  = 1'b1;
    step();
    start_i  = 1'b0;
    opcode_i = 8'($urandom);
  endtask

  // Returns how many edges passed before the block was ready for this operand.
  task automatic send_operand(input logic [W-1:0] val, input logic last, output int waited);
    operand_valid_i = 1'b1;
    operand_i = val;
    last_i = last;
    waited = 0;
    while (!operand_ready_o && waited < 200) begin
      step();
      waited++;
    end
    if (waited >= 200) check("operand_ready_timeout", 64'(operand_ready_o), 64'd1);
    step();
    operand_valid_i = 1'b0;
    last_i = 1'b0;
    operand_i = W'($urandom);
  endtask

  task automatic wait_result(input string tag, input logic [W:0] exp, input int exp_extra,
                             input int stall);
    int k;
    k = 0;
    while (!result_valid_o && k < 200) begin
      step();
      k++;
    end
    check({tag, "_latency"}, 64'(k), 64'(exp_extra));
    check({tag, "_result"}, 64'(result_o), 64'(exp[W-1:0]));
    check({tag, "_err"}, 64'(err_o), 64'(exp[W]));
    for (int s = 0; s < stall; s++) begin
      step();
      check({tag, "_hold"}, 64'({result_valid_o, err_o, result_o}), 64'({1'b1, exp}));
    end
    result_ready_i = 1'b1;
    step();
    result_ready_i = 1'b0;
    check({tag, "_valid_drop"}, 64'(result_valid_o), 64'd0);
  endtask

  initial begin
    int waited;
    int n;
    logic [7:0] op;
    logic [7:0] op_tab[4];
    op_tab[0] = OP_ECHO; op_tab[1] = OP_ADD; op_tab[2] = OP_MUL; op_tab[3] = OP_DIV;

    // Reset with a start request pending: reset must win.
    opcode_i = OP_ADD;
    start_i = 1'b1;
    operand_valid_i = 1'b1;
    repeat (3) step();
    check("reset_outputs",
          64'({operand_ready_o, result_valid_o, err_o, busy_o, result_o}), 64'd0);
    rst = 1'b0;
    start_i = 1'b0;
    repeat (3) step();
    check("idle_ignores_operand", 64'({operand_ready_o, busy_o, result_valid_o}), 64'd0);
    operand_valid_i = 1'b0;

    // Add with wrap.
    start_cmd(OP_ADD);
    check("busy_after_start", 64'(busy_o), 64'd1);
    send_operand(32'd5, 1'b0, waited);
    send_operand(32'd7, 1'b0, waited);
    send_operand(32'hFFFF_FFFF, 1'b1, waited);
    wait_result("add_wrap", {1'b0, 32'h0000_000B}, 0, 2);

    // Multiply 6*7, ready low for W cycles after each operand.
    start_cmd(OP_MUL);
    send_operand(32'd6, 1'b0, waited);
    send_operand(32'd7, 1'b1, waited);
    check("mul_ready_gap", 64'(waited), 64'(W));
    wait_result("mul_6x7", {1'b0, 32'd42}, W, 0);

    // Divide and divide by zero.
    start_cmd(OP_DIV);
    send_operand(32'd100, 1'b0, waited);
    send_operand(32'd7, 1'b0, waited);
    wait_result("div_100_7", {1'b0, 32'd14}, W, 1);
    start_cmd(OP_DIV);
    send_operand(32'd100, 1'b0, waited);
    send_operand(32'd0, 1'b1, waited);
    wait_result("div_zero", {1'b1, 32'hFFFF_FFFF}, 0, 0);
    start_cmd(OP_DIV);
    send_operand(32'd55, 1'b1, waited);
    wait_result("div_no_divisor", {1'b1, 32'd55}, 0, 0);

    // Illegal opcode, stalled consumer, stray start pulses.
    start_cmd(8'h00);
    check("illegal_latency", 64'(result_valid_o), 64'd1);
    check("illegal_value", 64'({err_o, result_o}), 64'({1'b1, 32'd0}));
    for (int s = 0; s < 5; s++) begin
      opcode_i = OP_ADD;
      start_i = s[0];
      step();
      check("illegal_hold", 64'({result_valid_o, err_o, result_o}), 64'({2'b11, 32'd0}));
    end
    start_i = 1'b1;
    result_ready_i = 1'b1;
    step();
    start_i = 1'b0;
    result_ready_i = 1'b0;
    check("start_with_xfer_ignored", 64'({busy_o, result_valid_o}), 64'd0);
    step();
    check("still_idle", 64'(busy_o), 64'd0);

    // Reset in the middle of a division aborts it.
    start_cmd(OP_DIV);
    send_operand(32'd100, 1'b0, waited);
    send_operand(32'd7, 1'b1, waited);
    repeat (10) step();
    rst = 1'b1;
    step();
    check("mid_div_reset",
          64'({operand_ready_o, result_valid_o, err_o, busy_o, result_o}), 64'd0);
    rst = 1'b0;
    n = 0;
    repeat (40) begin
      step();
      if (result_valid_o || busy_o) n++;
    end
    check("aborted_no_result", 64'(n), 64'd0);
    start_cmd(OP_ECHO);
    send_operand(32'hA5, 1'b1, waited);
    wait_result("echo_after_reset", {1'b0, 32'hA5}, 0, 0);

    // Randomized commands against the reference model.
    for (int t = 0; t < 25; t++) begin
      op = op_tab[$urandom_range(0, 3)];
      n = (op == OP_DIV) ? int'($urandom_range(1, 2)) : int'($urandom_range(1, 3));
      ops_q.delete();
      for (int i = 0; i < n; i++) begin
        logic [W-1:0] v;
        case ($urandom_range(0, 3))
          0: v = W'($urandom_range(0, 15));
          1: v = W'($urandom_range(0, 1000));
          default: v = W'($urandom);
        endcase
        if (op == OP_DIV && i == 1 && $urandom_range(0, 3) == 0) v = '0;
        ops_q.push_back(v);
      end
      start_cmd(op);
      for (int i = 0; i < n; i++) begin
        logic lst;
        lst = (i == n - 1) ? ((op == OP_DIV && i == 1) ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
        send_operand(ops_q[i], lst, waited);
        check("rand_ready_wait", 64'(waited), 64'((op == OP_MUL && i > 0) ? W : 0));
      end
      wait_result("rand_cmd", model(op),
                  (op == OP_MUL || (op == OP_DIV && n == 2 && ops_q[1] != 0)) ? W : 0,
                  int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
